// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - BIST response compactor (MISR) with serial signature unload
//
// Purpose:
//   Folds one CUT response word per CK into a multiple-input signature
//   register while BIST_en is high. After NPAT words it raises done and
//   compares the signature with GOLDEN. The signature can then be shifted
//   out LSB first through TDI/TDO under shiftdr.
//
// Ports:
//   CK       in   1      clock, all state on posedge
//   TRST     in   1      asynchronous active-low reset
//   BIST_en  in   1      BIST mode enable
//   resp     in   WIDTH  CUT response word, compacted each RUN cycle
//   shiftdr  in   1      shift-DR qualifier for signature unload
//   TDI      in   1      serial data in during unload
//   TDO      out  1      serial data out, always sig[0]
//   done     out  1      NPAT words have been compacted
//   pass     out  1      signature matched GOLDEN (valid while done=1)
//   sig      out  WIDTH  current MISR contents

module bist_misr #(
  parameter int               WIDTH  = 247,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(9),
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               NPAT   = 131071,
  parameter logic [WIDTH-1:0] GOLDEN = '0
) (
  input  logic             CK,
  input  logic             TRST,
  input  logic             BIST_en,
  input  logic [WIDTH-1:0] resp,
  input  logic             shiftdr,
  input  logic             TDI,
  output logic             TDO,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig
);

  localparam int            CW   = $clog2(NPAT + 1);
  localparam logic [CW-1:0] LAST = CW'(NPAT - 1);
  localparam logic [CW-1:0] FULL = CW'(NPAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [CW-1:0]    cnt_q;
  logic             en_q;
  logic             done_q;
  logic             pass_q;

  logic             start;
  logic [WIDTH-1:0] misr_d;       // MISR step from the current signature
  logic [WIDTH-1:0] seed_misr_d;  // MISR step from SEED (first word of a session)
  logic [WIDTH-1:0] unload_d;     // one-bit serial shift toward TDO

  always_comb begin
    start       = BIST_en & ~en_q;
    misr_d      = {sig_q[WIDTH-2:0], ^(sig_q & POLY)} ^ resp;
    seed_misr_d = {SEED[WIDTH-2:0], ^(SEED & POLY)} ^ resp;
    unload_d    = {TDI, sig_q[WIDTH-1:1]};
  end

  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      en_q <= BIST_en;
      case (state_q)
        // IDLE and DONE share session entry: the start edge reseeds and
        // compacts the first word in the same cycle. Start beats shiftdr.
        S_IDLE, S_DONE: begin
          if (start) begin
            sig_q <= seed_misr_d;
            cnt_q <= CW'(1);
            if (NPAT == 1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= (seed_misr_d == GOLDEN);
            end else begin
              state_q <= S_RUN;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end else if (shiftdr) begin
            sig_q <= unload_d;
          end
        end

        S_RUN: begin
          if (!BIST_en) begin
            // Abort: drop the partial signature without compacting this edge.
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            sig_q <= misr_d;
            if (cnt_q != FULL) begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (cnt_q == LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= (misr_d == GOLDEN);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sig  = sig_q;
  assign TDO  = sig_q[0];
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_bist_misr.sv
// tb/tb_bist_misr.sv - directed self-checking bench for bist_misr

module tb_bist_misr;

  logic       CK;
  logic       TRST;
  logic       BIST_en;
  logic [7:0] resp;
  logic       shiftdr;
  logic       TDI;
  logic       TDO;
  logic       done;
  logic       pass;
  logic [7:0] sig;

  int tests;
  int fails;

  bist_misr #(
    .WIDTH (8),
    .POLY  (8'h1D),
    .SEED  (8'h00),
    .NPAT  (4),
    .GOLDEN(8'h0E)
  ) dut (
    .CK     (CK),
    .TRST   (TRST),
    .BIST_en(BIST_en),
    .resp   (resp),
    .shiftdr(shiftdr),
    .TDI    (TDI),
    .TDO    (TDO),
    .done   (done),
    .pass   (pass),
    .sig    (sig)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs are then changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Session with resp 01,00,00,00: sig 01,03,07,0E, pass at the 4th edge.
  task automatic run_t2(input string tag);
    BIST_en = 1'b1;
    resp    = 8'h01;
    step();
    chk({tag, "_sig1"}, 32'(sig), 32'h01);
    chk({tag, "_done1"}, 32'(done), 32'h0);
    resp = 8'h00;
    step();
    chk({tag, "_sig2"}, 32'(sig), 32'h03);
    step();
    chk({tag, "_sig3"}, 32'(sig), 32'h07);
    chk({tag, "_done3"}, 32'(done), 32'h0);
    step();
    chk({tag, "_sig4"}, 32'(sig), 32'h0E);
    chk({tag, "_done4"}, 32'(done), 32'h1);
    chk({tag, "_pass4"}, 32'(pass), 32'h1);
  endtask

  logic [7:0] exp_tdo;

  initial begin
    tests   = 0;
    fails   = 0;
    TRST    = 1'b0;
    BIST_en = 1'b0;
    resp    = 8'h00;
    shiftdr = 1'b0;
    TDI     = 1'b0;

    // 1: reset
    #2;
    chk("rst_sig", 32'(sig), 32'h00);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_tdo", 32'(TDO), 32'h0);
    step();
    step();
    TRST = 1'b1;
    step();

    // 2: golden session
    run_t2("t2");

    // 3: all-zero response -> signature 00, fail
    BIST_en = 1'b0;
    step();
    chk("t3_hold_done", 32'(done), 32'h1);
    chk("t3_hold_sig", 32'(sig), 32'h0E);
    BIST_en = 1'b1;
    resp    = 8'h00;
    step();
    chk("t3_sig1", 32'(sig), 32'h00);
    chk("t3_done_clr", 32'(done), 32'h0);
    step();
    step();
    chk("t3_done3", 32'(done), 32'h0);
    step();
    chk("t3_done4", 32'(done), 32'h1);
    chk("t3_pass4", 32'(pass), 32'h0);
    resp = 8'hA5;
    step();
    chk("t3_sig5", 32'(sig), 32'h00);
    chk("t3_done5", 32'(done), 32'h1);

    // 4: abort after two RUN cycles, then restart
    BIST_en = 1'b0;
    step();
    BIST_en = 1'b1;
    resp    = 8'h01;
    step();
    resp = 8'h00;
    step();
    chk("t4_sig2", 32'(sig), 32'h03);
    BIST_en = 1'b0;
    step();
    chk("t4_abort_sig", 32'(sig), 32'h00);
    chk("t4_abort_done", 32'(done), 32'h0);
    chk("t4_abort_pass", 32'(pass), 32'h0);
    step();
    chk("t4_idle_sig", 32'(sig), 32'h00);
    run_t2("t4r");

    // 5: unload the 0E signature with TDI=1
    exp_tdo = 8'b0000_1110;
    shiftdr = 1'b1;
    TDI     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_tdo%0d", i), 32'(TDO), 32'(exp_tdo[i]));
      step();
    end
    chk("t5_sig", 32'(sig), 32'hFF);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_pass", 32'(pass), 32'h1);

    // start and shiftdr together: start wins, reseed from SEED
    shiftdr = 1'b0;
    BIST_en = 1'b0;
    step();
    BIST_en = 1'b1;
    shiftdr = 1'b1;
    resp    = 8'h01;
    step();
    chk("t5_start_wins", 32'(sig), 32'h01);
    chk("t5_start_done", 32'(done), 32'h0);
    shiftdr = 1'b0;
    resp    = 8'h00;
    step();
    chk("t6_pre_sig", 32'(sig), 32'h03);

    // 6: async reset mid-RUN, then full restart
    TRST    = 1'b0;
    BIST_en = 1'b0;
    #1;
    chk("t6_rst_sig", 32'(sig), 32'h00);
    chk("t6_rst_done", 32'(done), 32'h0);
    step();
    TRST = 1'b1;
    step();
    shiftdr = 1'b1;
    TDI     = 1'b1;
    step();
    chk("t6_idle_unload", 32'(sig), 32'h80);
    shiftdr = 1'b0;
    TDI     = 1'b0;
    run_t2("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
